booth_pp_accumulator: RTL and testbench

- Sequential consumer for the radix-2 Booth partial products produced by booth_encoder.
- Accepts one signed, pre-shifted partial product per cycle over a valid/ready stream and sums them modulo 2^(2*WIDTH).
- Presents the final product on a valid/ready output.
- Sits between the Booth partial-product generator and the multiplier result register in the single-cycle/multi-cycle multiplier datapath.

---
 rtl/booth_pp_accumulator_pkg.sv | 35 +++
 rtl/booth_pp_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_booth_pp_accumulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-2 Booth partial-product accumulator:
//   - booth_state_e : accumulator FSM states (IDLE, ACCUM, DONE)
//   - BOOTH_PROD_W  : product width for the default 4-bit operand width
//   - prod_width()  : product width (2*WIDTH) for a given operand width
//   - cnt_width()   : beat-counter width, enough to hold the value NPP
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } booth_state_e;

    localparam int BOOTH_WIDTH  = 32'sd4;
    localparam int BOOTH_PROD_W = 32'sd2 * BOOTH_WIDTH;

    function automatic int prod_width(input int width);
        return 32'sd2 * width;
    endfunction

    // Counter must be able to hold NPP itself, hence NPP+1 encodings.
    function automatic int cnt_width(input int npp);
        int w;
        if (npp < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = $clog2(npp + 32'sd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/booth_pp_accumulator.sv
// -----------------------------------------------------------------------------
// booth_pp_accumulator
// Sums a stream of signed, pre-shifted radix-2 Booth partial products modulo
// 2^(2*WIDTH) and presents the product on a valid/ready output.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   pp_valid   in   pp_data / pp_last valid
//   pp_ready   out  block can accept a partial product (0 while in DONE)
//   pp_data    in   [2*WIDTH] signed, already shifted partial product
//   pp_last    in   final partial product of the current multiply
//   prod_valid out  prod_data holds a completed product
//   prod_ready in   downstream accepts the product
//   prod_data  out  [2*WIDTH] two's-complement product
//   err_len    out  partial-product count mismatch, valid with prod_valid
//
// Build option:
//   BOOTH_ACC_LEN_CHECK_EN - when defined, the NPP-th beat forces completion
//   and a short or over-long stream raises err_len. When undefined err_len is
//   always 0 and accumulation runs until pp_last.
// -----------------------------------------------------------------------------
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NPP   = WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pp_valid,
    output logic                      pp_ready,
    input  logic [2*WIDTH-1:0]        pp_data,
    input  logic                      pp_last,
    output logic                      prod_valid,
    input  logic                      prod_ready,
    output logic [2*WIDTH-1:0]        prod_data,
    output logic                      err_len
);

    localparam int PW    = prod_width(WIDTH);
    localparam int CNT_W = cnt_width(NPP);

    booth_state_e      state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pp_ready_q, pp_ready_d;
    logic              prod_valid_q, prod_valid_d;
    logic [PW-1:0]     prod_data_q, prod_data_d;
    logic              err_len_q, err_len_d;

    logic              pp_xfer_s;
    logic              prod_xfer_s;
    logic              finish_s;
    logic              len_err_s;

`ifdef BOOTH_ACC_LEN_CHECK_EN
    localparam logic [CNT_W:0] NPP_EXT = (CNT_W + 1)'(NPP);
    localparam logic [CNT_W:0] ONE_EXT = (CNT_W + 1)'(1'b1);
    logic [CNT_W:0]    cnt_ext_s;

    // Count including the beat being accepted; widened so it cannot wrap.
    always_comb begin
        cnt_ext_s = ONE_EXT;
        finish_s  = 1'b0;
        len_err_s = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_ext_s = ONE_EXT;
        end else begin
            cnt_ext_s = {1'b0, cnt_q} + ONE_EXT;
        end
        // Reaching NPP beats without pp_last ends the multiply as an error;
        // pp_last before NPP beats is a short stream.
        if (pp_last) begin
            finish_s  = 1'b1;
            len_err_s = (cnt_ext_s < NPP_EXT);
        end else begin
            finish_s  = (cnt_ext_s >= NPP_EXT);
            len_err_s = (cnt_ext_s >= NPP_EXT);
        end
    end
`else
    logic              cnt_unused_s;

    // Without the length check only pp_last ends a multiply; cnt is informational.
    always_comb begin
        finish_s  = pp_last;
        len_err_s = 1'b0;
    end

    assign cnt_unused_s = ^cnt_q;
`endif

    assign pp_xfer_s   = pp_valid && pp_ready_q;
    assign prod_xfer_s = prod_valid_q && prod_ready;

    // Next-state, accumulator and output-register computation.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        prod_data_d = prod_data_q;
        err_len_d   = err_len_q;
        case (state_q)
            ST_IDLE: begin
                if (pp_xfer_s) begin
                    // First beat loads rather than adds, so no clear cycle is needed.
                    acc_d = pp_data;
                    cnt_d = CNT_W'(1'b1);
                    if (finish_s) begin
                        state_d     = ST_DONE;
                        prod_data_d = pp_data;
                        err_len_d   = len_err_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (pp_xfer_s) begin
                    acc_d = acc_q + pp_data;
                    cnt_d = cnt_q + CNT_W'(1'b1);
                    if (finish_s) begin
                        state_d     = ST_DONE;
                        prod_data_d = acc_q + pp_data;
                        err_len_d   = len_err_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                // prod_data is left holding the result; only err_len clears.
                if (prod_xfer_s) begin
                    state_d   = ST_IDLE;
                    err_len_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                err_len_d = 1'b0;
            end
        endcase
        // Handshake flags are decoded from the next state so they register
        // in step with the FSM and never see pp_valid combinationally.
        pp_ready_d   = (state_d != ST_DONE);
        prod_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= {PW{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            pp_ready_q   <= 1'b0;
            prod_valid_q <= 1'b0;
            prod_data_q  <= {PW{1'b0}};
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pp_ready_q   <= pp_ready_d;
            prod_valid_q <= prod_valid_d;
            prod_data_q  <= prod_data_d;
            err_len_q    <= err_len_d;
        end
    end

    assign pp_ready   = pp_ready_q;
    assign prod_valid = prod_valid_q;
    assign prod_data  = prod_data_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_accumulator
// Directed bench for booth_pp_accumulator (WIDTH=4, NPP=4). Inputs change 1ns
// after the rising edge; outputs are read 1ns after the rising edge or on the
// falling edge. Honours BOOTH_ACC_LEN_CHECK_EN for the length-error cases.
// -----------------------------------------------------------------------------
module tb_booth_pp_accumulator;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          pp_valid;
    logic          pp_ready;
    logic [PW-1:0] pp_data;
    logic          pp_last;
    logic          prod_valid;
    logic          prod_ready;
    logic [PW-1:0] prod_data;
    logic          err_len;

    int n_checks = 0;
    int n_fails  = 0;

    booth_pp_accumulator #(.WIDTH(W), .NPP(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pp_valid   (pp_valid),
        .pp_ready   (pp_ready),
        .pp_data    (pp_data),
        .pp_last    (pp_last),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .err_len    (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_pp(input logic [PW-1:0] d, input logic l);
        int n;
        n        = 0;
        pp_valid = 1'b1;
        pp_data  = d;
        pp_last  = l;
        @(negedge clk);
        while (!pp_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!pp_ready) check_eq("pp_ready_wait", {31'd0, pp_ready}, 32'd1);
        @(posedge clk);
        #1;
        pp_valid = 1'b0;
        pp_last  = 1'b0;
    endtask

    // Called 1ns after the last accept: product must already be visible,
    // then drain it with prod_ready high and confirm prod_valid drops.
    task automatic take_prod(input string tag, input logic [PW-1:0] exp, input logic exp_err);
        check_eq({tag, "_valid"}, {31'd0, prod_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, prod_data}, {24'd0, exp});
        check_eq({tag, "_err"}, {31'd0, err_len}, {31'd0, exp_err});
        prod_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_drop"}, {31'd0, prod_valid}, 32'd0);
    endtask

    function automatic logic [PW-1:0] booth_pp(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        logic [W:0]    bx;
        logic [PW-1:0] ax;
        logic [PW-1:0] r;
        bx = {b, 1'b0};
        ax = {{W{a[W-1]}}, a};
        case ({bx[i+1], bx[i]})
            2'b01:   r = ax << i;
            2'b10:   r = -(ax << i);
            default: r = '0;
        endcase
        return r;
    endfunction

    initial begin
        logic [W-1:0]         a, b;
        logic signed [PW-1:0] ea, eb, ep;
        int                   gap;

        rst_n      = 1'b0;
        pp_valid   = 1'b0;
        pp_data    = '0;
        pp_last    = 1'b0;
        prod_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_pp_ready", {31'd0, pp_ready}, 32'd0);
        check_eq("rst_prod_valid", {31'd0, prod_valid}, 32'd0);
        check_eq("rst_prod_data", {24'd0, prod_data}, 32'd0);
        check_eq("rst_err_len", {31'd0, err_len}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_pp_ready", {31'd0, pp_ready}, 32'd1);

        // 7 * 5 = 35
        send_pp(8'hF9, 1'b0);
        send_pp(8'h0E, 1'b0);
        send_pp(8'hE4, 1'b0);
        check_eq("accum_no_valid", {31'd0, prod_valid}, 32'd0);
        send_pp(8'h38, 1'b1);
        check_eq("done_pp_ready", {31'd0, pp_ready}, 32'd0);
        take_prod("mul_7x5", 8'h23, 1'b0);
        check_eq("bubble_pp_ready", {31'd0, pp_ready}, 32'd1);

        // 3 * -2 = -6
        send_pp(8'h00, 1'b0);
        send_pp(8'hFA, 1'b0);
        send_pp(8'h00, 1'b0);
        send_pp(8'h00, 1'b1);
        take_prod("mul_3xm2", 8'hFA, 1'b0);

        // -8 * -8 = 64 with downstream stalled for 3 cycles
        prod_ready = 1'b0;
        send_pp(8'h00, 1'b0);
        send_pp(8'h00, 1'b0);
        send_pp(8'h00, 1'b0);
        send_pp(8'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", {31'd0, prod_valid}, 32'd1);
            check_eq("stall_data", {24'd0, prod_data}, 32'h40);
            check_eq("stall_pp_ready", {31'd0, pp_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        take_prod("mul_m8xm8", 8'h40, 1'b0);

        // Wrap without saturation: 0x70 + 0x70 = 0xE0
        send_pp(8'h70, 1'b0);
        send_pp(8'h70, 1'b0);
        send_pp(8'h00, 1'b0);
        send_pp(8'h00, 1'b1);
        take_prod("wrap", 8'hE0, 1'b0);

        // Single-beat multiply
        send_pp(8'h5A, 1'b1);
`ifdef BOOTH_ACC_LEN_CHECK_EN
        take_prod("single", 8'h5A, 1'b1);
`else
        take_prod("single", 8'h5A, 1'b0);
`endif

        // Reset in the middle of a multiply, then a clean 7 * 5
        send_pp(8'hF9, 1'b0);
        send_pp(8'h0E, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pp_ready", {31'd0, pp_ready}, 32'd0);
        check_eq("midrst_prod_valid", {31'd0, prod_valid}, 32'd0);
        check_eq("midrst_prod_data", {24'd0, prod_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pp(8'hF9, 1'b0);
        send_pp(8'h0E, 1'b0);
        send_pp(8'hE4, 1'b0);
        send_pp(8'h38, 1'b1);
        take_prod("post_rst_7x5", 8'h23, 1'b0);

        // Length handling
`ifdef BOOTH_ACC_LEN_CHECK_EN
        send_pp(8'hF9, 1'b0);
        send_pp(8'h0E, 1'b1);
        take_prod("len_short", 8'h07, 1'b1);
        send_pp(8'hF9, 1'b0);
        send_pp(8'h0E, 1'b0);
        send_pp(8'hE4, 1'b0);
        send_pp(8'h38, 1'b0);
        take_prod("len_nolast", 8'h23, 1'b1);
`else
        send_pp(8'hF9, 1'b0);
        send_pp(8'h0E, 1'b0);
        send_pp(8'hE4, 1'b0);
        send_pp(8'h38, 1'b0);
        check_eq("len_no_early_done", {31'd0, prod_valid}, 32'd0);
        send_pp(8'h01, 1'b1);
        take_prod("len_five", 8'h24, 1'b0);
`endif

        // 200 random signed 4x4 pairs with gaps on pp_valid, prod_ready tied 1
        for (int k = 0; k < 200; k++) begin
            a  = W'($urandom_range(0, 15));
            b  = W'($urandom_range(0, 15));
            ea = {{W{a[W-1]}}, a};
            eb = {{W{b[W-1]}}, b};
            ep = ea * eb;
            for (int i = 0; i < W; i++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                send_pp(booth_pp(a, b, i), (i == W - 1));
            end
            check_eq("rand_valid", {31'd0, prod_valid}, 32'd1);
            check_eq("rand_prod", {24'd0, prod_data}, {24'd0, ep});
            @(posedge clk);
            #1;
            check_eq("rand_bubble", {31'd0, pp_ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
